map_cell_mover: RTL and testbench

Read-modify-write engine on port B of `map_RAM` that moves one sprite cell on the 40×30 tile map. It accepts a move request from the sprite controllers (pacman/ghost location logic), clears the source cell to a fill code, writes the sprite code into the destination cell, and reports what the destination held before the move as the collision type. It sits between the location controllers and the map RAM write port; the VGA path reads port A unaffected.

---
 rtl/map_cell_mover.sv | 242 ++++++++++++++++++++++++
 tb/tb_map_cell_mover.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/map_cell_mover.sv
// map_cell_mover: read-modify-write engine on map_RAM port B that moves one
// sprite cell on the 40x30 tile map. The source cell is cleared to `fill`,
// the destination cell receives `code`, and the destination's prior contents
// are reported on `hit`.
//
// Optional feature macro: MAP_MOVE_WALL_BLOCK_EN
//   defined   -> a destination holding WALL_CODE aborts the move (rejected=1)
//   undefined -> every in-range move is performed, walls included
//
// Ports:
//   CLOCK_50          system clock
//   reset             synchronous, active-high
//   req               move request, sampled only while idle
//   src_x/src_y       source cell (x 0-39, y 0-29)
//   dst_x/dst_y       destination cell
//   code / fill       code written at destination / left behind at source
//   busy              high from the cycle after acceptance until done
//   done              one-cycle completion pulse
//   rejected          valid with done; move not performed
//   hit               destination code before the move (held until next accept)
//   wraddr/wren/wrdata port-B row address, write enable, write row
//   redata            port-B read row
module map_cell_mover #(
    parameter int unsigned RD_LAT    = 1,
    parameter logic [3:0]  WALL_CODE = 4'h1
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    input  logic           req,
    input  logic [5:0]     src_x,
    input  logic [4:0]     src_y,
    input  logic [5:0]     dst_x,
    input  logic [4:0]     dst_y,
    input  logic [3:0]     code,
    input  logic [3:0]     fill,
    output logic           busy,
    output logic           done,
    output logic           rejected,
    output logic [3:0]     hit,
    output logic [4:0]     wraddr,
    output logic           wren,
    output logic [159:0]   wrdata,
    input  logic [159:0]   redata
);

    localparam int unsigned ROW_W = 160;
    localparam int unsigned CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [5:0]  X_MAX = 6'd39;
    localparam logic [4:0]  Y_MAX = 5'd29;

`ifdef MAP_MOVE_WALL_BLOCK_EN
    localparam bit WALL_BLOCK = 1'b1;
`else
    localparam bit WALL_BLOCK = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_DST,
        S_RD_SRC,
        S_WR_SRC,
        S_RD_DST2,
        S_WR_DST,
        S_DONE
    } state_e;

    // Cell x lives at row[159-4x -: 4]; shifting left by 4x brings it to the top.
    function automatic logic [3:0] get_nib(input logic [ROW_W-1:0] row,
                                           input logic [5:0]       x);
        logic [ROW_W-1:0] sh;
        sh = row << {x, 2'b00};
        return sh[ROW_W-1 -: 4];
    endfunction

    // Replace only cell x; the other 39 nibbles pass through.
    function automatic logic [ROW_W-1:0] put_nib(input logic [ROW_W-1:0] row,
                                                 input logic [5:0]       x,
                                                 input logic [3:0]       nib);
        logic [ROW_W-1:0] mask;
        logic [ROW_W-1:0] ins;
        mask = {4'hF, {(ROW_W-4){1'b0}}} >> {x, 2'b00};
        ins  = {nib,  {(ROW_W-4){1'b0}}} >> {x, 2'b00};
        return (row & ~mask) | ins;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         sx_q, sx_d, dx_q, dx_d;
    logic [4:0]         sy_q, sy_d, dy_q, dy_d;
    logic [3:0]         code_q, code_d, fill_q, fill_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rejected_q, rejected_d;
    logic [3:0]         hit_q, hit_d;
    logic [4:0]         wraddr_q, wraddr_d;
    logic               wren_q, wren_d;
    logic [ROW_W-1:0]   wrdata_q, wrdata_d;

    logic               rd_last_c;
    logic               range_bad_c;
    logic [3:0]         dst_nib_c;

    assign rd_last_c   = (cnt_q == CNT_W'(RD_LAT));
    assign range_bad_c = (src_x > X_MAX) || (dst_x > X_MAX) ||
                         (src_y > Y_MAX) || (dst_y > Y_MAX);
    assign dst_nib_c   = get_nib(redata, dx_q);

    // State and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            code_q     <= '0;
            fill_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rejected_q <= 1'b0;
            hit_q      <= '0;
            wraddr_q   <= '0;
            wren_q     <= 1'b0;
            wrdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            code_q     <= code_d;
            fill_q     <= fill_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rejected_q <= rejected_d;
            hit_q      <= hit_d;
            wraddr_q   <= wraddr_d;
            wren_q     <= wren_d;
            wrdata_q   <= wrdata_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they line
    // up with the state they describe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        code_d     = code_q;
        fill_d     = fill_q;
        hit_d      = hit_q;
        rejected_d = 1'b0;
        wrdata_d   = wrdata_q;
        wraddr_d   = wraddr_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    sx_d   = src_x;
                    sy_d   = src_y;
                    dx_d   = dst_x;
                    dy_d   = dst_y;
                    code_d = code;
                    fill_d = fill;
                    cnt_d  = '0;
                    if (range_bad_c) begin
                        state_d    = S_DONE;
                        rejected_d = 1'b1;
                        hit_d      = 4'h0;
                    end else begin
                        state_d = S_RD_DST;
                    end
                end
            end
            // Check of the captured destination is folded into this exit.
            S_RD_DST: begin
                if (rd_last_c) begin
                    hit_d = dst_nib_c;
                    cnt_d = '0;
                    if (WALL_BLOCK && (dst_nib_c == WALL_CODE)) begin
                        state_d    = S_DONE;
                        rejected_d = 1'b1;
                    end else begin
                        state_d = S_RD_SRC;
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            S_RD_SRC: begin
                if (rd_last_c) begin
                    wrdata_d = put_nib(redata, sx_q, fill_q);
                    cnt_d    = '0;
                    state_d  = S_WR_SRC;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            S_WR_SRC: begin
                cnt_d   = '0;
                state_d = S_RD_DST2;
            end
            // Re-read so a same-row move merges onto the just-written source.
            S_RD_DST2: begin
                if (rd_last_c) begin
                    wrdata_d = put_nib(redata, dx_q, code_q);
                    cnt_d    = '0;
                    state_d  = S_WR_DST;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            S_WR_DST: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        case (state_d)
            S_RD_DST, S_RD_DST2, S_WR_DST: wraddr_d = dy_d;
            S_RD_SRC, S_WR_SRC:            wraddr_d = sy_d;
            default:                       wraddr_d = wraddr_q;
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
        wren_d = (state_d == S_WR_SRC) || (state_d == S_WR_DST);
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rejected = rejected_q;
    assign hit      = hit_q;
    assign wraddr   = wraddr_q;
    assign wren     = wren_q;
    assign wrdata   = wrdata_q;

endmodule

// File: tb/tb_map_cell_mover.sv
// Directed bench for map_cell_mover with a behavioural 1-cycle-latency map RAM.
// Cycle numbering: the accepting edge is k; the cycle starting at that edge
// is cycle k+1, so done in cycle 9 means "done at k+9".
module tb_map_cell_mover;

    logic         clk = 1'b0;
    logic         reset;
    logic         req;
    logic [5:0]   src_x, dst_x;
    logic [4:0]   src_y, dst_y;
    logic [3:0]   code, fill;
    logic         busy, done, rejected, wren;
    logic [3:0]   hit;
    logic [4:0]   wraddr;
    logic [159:0] wrdata, redata;

    logic [159:0] mem [0:31];
    int           wren_cnt = 0;
    int           n_chk = 0;
    int           n_bad = 0;

    always #10 clk = ~clk;

    map_cell_mover #(.RD_LAT(1), .WALL_CODE(4'h1)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .req      (req),
        .src_x    (src_x),
        .src_y    (src_y),
        .dst_x    (dst_x),
        .dst_y    (dst_y),
        .code     (code),
        .fill     (fill),
        .busy     (busy),
        .done     (done),
        .rejected (rejected),
        .hit      (hit),
        .wraddr   (wraddr),
        .wren     (wren),
        .wrdata   (wrdata),
        .redata   (redata)
    );

    // Port-B model: registered read, one cycle latency, write-first not needed.
    always @(posedge clk) begin
        if (wren) begin
            mem[wraddr] <= wrdata;
            wren_cnt    <= wren_cnt + 1;
        end
        redata <= mem[wraddr];
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] setn(input logic [159:0] r, input int x, input logic [3:0] v);
        r[159-4*x -: 4] = v;
        return r;
    endfunction

    task automatic load_row(input int y, input logic [159:0] d);
        @(negedge clk);
        mem[y] <= d;
        @(negedge clk);
    endtask

    // Issue a move with req held high until done; returns the done cycle
    // (0 if it never came), flags at done, busy in cycle k+1, wren pulses,
    // and whether busy rose again afterwards.
    task automatic do_move(input int sx, input int sy, input int dx, input int dy,
                           input logic [3:0] c, input logic [3:0] f,
                           output int lat, output logic rej, output logic [3:0] h,
                           output logic busy1, output int nwr, output logic extra);
        int w0;
        int cyc;
        @(negedge clk);
        src_x = 6'(sx); src_y = 5'(sy); dst_x = 6'(dx); dst_y = 5'(dy);
        code = c; fill = f; req = 1'b1;
        w0 = wren_cnt;
        @(posedge clk); #1;
        busy1 = busy;
        cyc = 1;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        lat = done ? cyc : 0;
        rej = rejected;
        h   = hit;
        req = 1'b0;
        extra = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (busy || done) extra = 1'b1;
        end
        nwr = wren_cnt - w0;
    endtask

    int           lat, nwr;
    logic         rej, busy1, extra;
    logic [3:0]   h;
    logic [159:0] r;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        reset = 1'b1; req = 1'b0;
        src_x = '0; src_y = '0; dst_x = '0; dst_y = '0; code = '0; fill = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 160'(busy), 160'(0));
        check("rst_done", 160'(done), 160'(0));
        check("rst_rej", 160'(rejected), 160'(0));
        check("rst_hit", 160'(hit), 160'(0));
        check("rst_wren", 160'(wren), 160'(0));
        check("rst_wraddr", 160'(wraddr), 160'(0));
        check("rst_wrdata", wrdata, 160'(0));
        @(negedge clk); reset = 1'b0;

        // Same-row move, pill in destination, req held through busy.
        r = '0; r = setn(r, 2, 4'h8); r = setn(r, 3, 4'h2);
        load_row(5, r);
        do_move(2, 5, 3, 5, 4'h8, 4'h0, lat, rej, h, busy1, nwr, extra);
        check("t1_busy1", 160'(busy1), 160'(1));
        check("t1_lat", 160'(lat), 160'(9));
        check("t1_hit", 160'(h), 160'(4'h2));
        check("t1_rej", 160'(rej), 160'(0));
        check("t1_nwr", 160'(nwr), 160'(2));
        check("t1_once", 160'(extra), 160'(0));
        check("t1_row5", mem[5], setn(160'(0), 3, 4'h8));

        // Cross-row move; all other nibbles must be untouched.
        load_row(4, setn({40{4'h3}}, 10, 4'h9));
        load_row(5, {40{4'h5}});
        do_move(10, 4, 10, 5, 4'h9, 4'h0, lat, rej, h, busy1, nwr, extra);
        check("t2_lat", 160'(lat), 160'(9));
        check("t2_hit", 160'(h), 160'(4'h5));
        check("t2_row4", mem[4], setn({40{4'h3}}, 10, 4'h0));
        check("t2_row5", mem[5], setn({40{4'h5}}, 10, 4'h9));

        // Wall at destination (0,0).
        r = '0; r = setn(r, 0, 4'h1); r = setn(r, 1, 4'h6);
        load_row(0, r);
        do_move(1, 0, 0, 0, 4'h6, 4'h0, lat, rej, h, busy1, nwr, extra);
        check("t3_busy1", 160'(busy1), 160'(1));
        check("t3_hit", 160'(h), 160'(4'h1));
`ifdef MAP_MOVE_WALL_BLOCK_EN
        check("t3_lat", 160'(lat), 160'(3));
        check("t3_rej", 160'(rej), 160'(1));
        check("t3_nwr", 160'(nwr), 160'(0));
        check("t3_row0", mem[0], r);
`else
        check("t3_lat", 160'(lat), 160'(9));
        check("t3_rej", 160'(rej), 160'(0));
        check("t3_nwr", 160'(nwr), 160'(2));
        check("t3_row0", mem[0], setn(160'(0), 0, 4'h6));
`endif

        // Out of range: dst_x=40, then src_y=30.
        do_move(0, 0, 40, 0, 4'h8, 4'h0, lat, rej, h, busy1, nwr, extra);
        check("t4_lat", 160'(lat), 160'(1));
        check("t4_rej", 160'(rej), 160'(1));
        check("t4_hit", 160'(h), 160'(0));
        check("t4_nwr", 160'(nwr), 160'(0));
        check("t4_busy1", 160'(busy1), 160'(0));
        check("t4_once", 160'(extra), 160'(0));
        do_move(0, 30, 0, 0, 4'h8, 4'h0, lat, rej, h, busy1, nwr, extra);
        check("t4b_lat", 160'(lat), 160'(1));
        check("t4b_rej", 160'(rej), 160'(1));
        check("t4b_nwr", 160'(nwr), 160'(0));

        // src == dst at (20,10): final cell holds code, hit is prior contents.
        load_row(10, setn(160'(0), 20, 4'hA));
        do_move(20, 10, 20, 10, 4'hB, 4'h0, lat, rej, h, busy1, nwr, extra);
        check("t5_lat", 160'(lat), 160'(9));
        check("t5_hit", 160'(h), 160'(4'hA));
        check("t5_row10", mem[10], setn(160'(0), 20, 4'hB));

        // Reset during WR_SRC leaves the source cleared and issues no done.
        load_row(6, setn(160'(0), 5, 4'h7));
        @(negedge clk);
        src_x = 6'd5; src_y = 5'd6; dst_x = 6'd6; dst_y = 5'd6; code = 4'h7; fill = 4'h0;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (!wren && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("t6_wren_seen", 160'(wren), 160'(1));
            reset = 1'b1;
            @(posedge clk); #1;
            check("t6_busy", 160'(busy), 160'(0));
            check("t6_wren", 160'(wren), 160'(0));
            check("t6_done", 160'(done), 160'(0));
            reset = 1'b0;
            extra = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                if (done) extra = 1'b1;
            end
            check("t6_nodone", 160'(extra), 160'(0));
            check("t6_row6", mem[6], 160'(0));
        end

        // Recovery move to the far column x=39.
        load_row(7, setn(160'(0), 0, 4'h8));
        do_move(0, 7, 39, 7, 4'h8, 4'h0, lat, rej, h, busy1, nwr, extra);
        check("t7_lat", 160'(lat), 160'(9));
        check("t7_rej", 160'(rej), 160'(0));
        check("t7_hit", 160'(h), 160'(0));
        check("t7_row7", mem[7], setn(160'(0), 39, 4'h8));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
